cbd_collect: RTL and testbench

//  Sits directly upstream of the CBD sampler: gathers SHAKE256 (PRF) squeeze words into
//  the 1536-bit byte bus the sampler consumes. Collects 64*eta bytes per polynomial,

---
 rtl/cbd_collect_pkg.sv | 23 ++
 rtl/cbd_collect.sv | 134 +++++++++++++
 tb/tb_cbd_collect.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbd_collect_pkg.sv
// Shared types and constants for the CBD input collector.
// State encoding and the per-eta byte counts live here.
package cbd_collect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CBD_N          = 256;
    localparam int CBD_BYTES_ETA2 = 128;
    localparam int CBD_BYTES_ETA3 = 192;

    function automatic int beats_for_bytes(input int n_bytes, input int w_din);
        return (n_bytes * 8) / w_din;
    endfunction

    function automatic logic eta_is_legal(input logic [1:0] eta);
        return (eta == 2'd2) || (eta == 2'd3);
    endfunction

endpackage

// File: rtl/cbd_collect.sv
// Gathers SHAKE256 squeeze words into the byte bus consumed by the CBD sampler.
// Optional sticky protocol checker enabled by defining CBD_COLLECT_ERR_EN.
module cbd_collect
    import cbd_collect_pkg::*;
#(
    parameter int W_DIN   = 64,
    parameter int N_BYTES = 192
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_start,
    input  logic [1:0]             i_eta,
    input  logic [W_DIN-1:0]       i_din,
    input  logic                   i_din_valid,
    output logic                   o_din_ready,
    output logic [N_BYTES*8-1:0]   o_ibytes,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic                   o_err
);

    localparam int TOT_BITS  = N_BYTES * 8;
    localparam int BPW       = W_DIN / 8;
    localparam int MAX_BEATS = beats_for_bytes(N_BYTES, W_DIN);
    localparam int NB_ETA2   = beats_for_bytes(CBD_BYTES_ETA2, W_DIN);
    localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [CNT_W-1:0] LAST_ETA2 = CNT_W'(NB_ETA2 - 1);
    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(MAX_BEATS - 1);

    state_e               state_q;
    logic [CNT_W-1:0]     count_q;
    logic                 eta2_q;
    logic [TOT_BITS-1:0]  ibytes_q;
    logic [TOT_BITS-1:0]  ibytes_d;
    logic                 valid_q;
    logic                 din_ready_q;
    logic [W_DIN-1:0]     din_rev;
    logic                 beat_fire;
    logic                 last_beat;

    // Byte 0 of the stream sits at the top of the bus, so each word is byte-reversed
    // before it lands in its slot.
    always_comb begin
        din_rev  = '0;
        ibytes_d = ibytes_q;
        for (int j = 0; j < BPW; j++) begin
            din_rev[W_DIN-1-8*j -: 8] = i_din[8*j +: 8];
        end
        for (int c = 0; c < MAX_BEATS; c++) begin
            if (count_q == CNT_W'(c)) begin
                ibytes_d[TOT_BITS-1-c*W_DIN -: W_DIN] = din_rev;
            end
        end
    end

    assign beat_fire = din_ready_q & i_din_valid;
    assign last_beat = (count_q == (eta2_q ? LAST_ETA2 : LAST_FULL));

    // Collection FSM; i_start restarts from any state and beats any same-cycle event.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            eta2_q      <= 1'b0;
            ibytes_q    <= '0;
            valid_q     <= 1'b0;
            din_ready_q <= 1'b0;
        end else if (i_start) begin
            state_q     <= ST_FILL;
            count_q     <= '0;
            eta2_q      <= (i_eta == 2'd2);
            ibytes_q    <= '0;
            valid_q     <= 1'b0;
            din_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_FILL: begin
                    if (beat_fire) begin
                        ibytes_q <= ibytes_d;
                        if (last_beat) begin
                            state_q     <= ST_DONE;
                            count_q     <= '0;
                            valid_q     <= 1'b1;
                            din_ready_q <= 1'b0;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    count_q     <= '0;
                    valid_q     <= 1'b0;
                    din_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ibytes    = ibytes_q;
    assign o_valid     = valid_q;
    assign o_din_ready = din_ready_q;
    assign o_busy      = (state_q != ST_IDLE);

`ifdef CBD_COLLECT_ERR_EN
    logic err_q;

    // Sticky until the next start, which re-evaluates only the new eta.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            err_q <= 1'b0;
        end else if (i_start) begin
            err_q <= !eta_is_legal(i_eta);
        end else if (i_din_valid && (state_q != ST_FILL)) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_cbd_collect.sv
// Self-checking bench for cbd_collect: scenario tasks plus a randomized run,
// all compared against a byte-list reference model.
module tb_cbd_collect;

    localparam int W   = 64;
    localparam int NBY = 192;
    localparam int TOT = NBY * 8;
`ifdef CBD_COLLECT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           i_clk = 1'b0;
    logic           i_rstn = 1'b0;
    logic           i_start = 1'b0;
    logic [1:0]     i_eta = 2'd0;
    logic [W-1:0]   i_din = '0;
    logic           i_din_valid = 1'b0;
    logic           i_ready = 1'b0;
    logic           o_din_ready;
    logic [TOT-1:0] o_ibytes;
    logic           o_valid;
    logic           o_busy;
    logic           o_err;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 holding a full bus.
    int           m_phase;
    int           m_need;
    logic [7:0]   m_bytes[$];
    bit           m_err;

    cbd_collect #(.W_DIN(W), .N_BYTES(NBY)) dut (
        .i_clk(i_clk),
        .i_rstn(i_rstn),
        .i_start(i_start),
        .i_eta(i_eta),
        .i_din(i_din),
        .i_din_valid(i_din_valid),
        .o_din_ready(o_din_ready),
        .o_ibytes(o_ibytes),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_busy(o_busy),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [TOT-1:0] m_bus();
        logic [TOT-1:0] b;
        b = '0;
        for (int k = 0; k < m_bytes.size(); k++) b[TOT-1-8*k -: 8] = m_bytes[k];
        return b;
    endfunction

    function automatic bit exp_err();
        return ERR_EN ? m_err : 1'b0;
    endfunction

    function automatic int bus_diff(input logic [TOT-1:0] a, input logic [TOT-1:0] b);
        for (int k = 0; k < NBY; k++) begin
            if (a[TOT-1-8*k -: 8] !== b[TOT-1-8*k -: 8]) return k;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_need  = 0;
        m_bytes.delete();
        m_err   = 1'b0;
    endtask

    // Advance the model by the inputs currently driven, then step one clock.
    task automatic tick();
        if (i_start) begin
            m_phase = 1;
            m_need  = (i_eta == 2'd2) ? 128 : 192;
            m_bytes.delete();
            m_err   = !(i_eta == 2'd2 || i_eta == 2'd3);
        end else begin
            if (i_din_valid && m_phase != 1) m_err = 1'b1;
            if (m_phase == 1 && i_din_valid) begin
                for (int j = 0; j < W / 8; j++) m_bytes.push_back(i_din[8*j +: 8]);
                if (m_bytes.size() >= m_need) m_phase = 2;
            end else if (m_phase == 2 && i_ready) begin
                m_phase = 0;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_idle();
        i_start     = 1'b0;
        i_din_valid = 1'b0;
        i_ready     = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", o_valid); end
        checks++;
        if (o_din_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_din_ready got %b want 0", o_din_ready); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", o_busy); end
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", o_err); end
        checks++;
        if (o_ibytes !== '0) begin errors++; $display("[TB] FAIL reset_bus byte %0d got %02h want 00", bus_diff(o_ibytes, '0), o_ibytes[TOT-1-8*bus_diff(o_ibytes, '0) -: 8]); end
    endtask

    task automatic test_eta2_sequential();
        logic [TOT-1:0] expect_bus;
        int k;
        i_start = 1'b1; i_eta = 2'd2; i_ready = 1'b1;
        tick();
        i_start = 1'b0;
        checks++;
        if (o_din_ready !== 1'b1) begin errors++; $display("[TB] FAIL eta2_ready_after_start got %b want 1", o_din_ready); end
        for (int c = 0; c < 16; c++) begin
            for (int j = 0; j < 8; j++) i_din[8*j +: 8] = 8'(c * 8 + j);
            i_din_valid = 1'b1;
            tick();
            checks++;
            if (o_valid !== (c == 15)) begin errors++; $display("[TB] FAIL eta2_valid_beat%0d got %b want %b", c, o_valid, (c == 15)); end
        end
        i_din_valid = 1'b0;
        checks++;
        if (o_din_ready !== 1'b0) begin errors++; $display("[TB] FAIL eta2_ready_done got %b want 0", o_din_ready); end
        expect_bus = '0;
        for (k = 0; k < 128; k++) expect_bus[TOT-1-8*k -: 8] = 8'(k);
        checks++;
        if (o_ibytes !== expect_bus) begin
            errors++;
            k = bus_diff(o_ibytes, expect_bus);
            $display("[TB] FAIL eta2_bus byte %0d got %02h want %02h", k, o_ibytes[TOT-1-8*k -: 8], expect_bus[TOT-1-8*k -: 8]);
        end
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("[TB] FAIL eta2_idle busy=%b valid=%b want 0 0", o_busy, o_valid); end
        drive_idle();
    endtask

    task automatic test_eta3_backpressure();
        int budget;
        int k;
        i_start = 1'b1; i_eta = 2'd3; i_ready = 1'b0;
        tick();
        i_start = 1'b0;
        budget = 0;
        while (m_phase == 1 && budget < 200) begin
            i_din_valid = budget[0] == 1'b0;
            i_din = {$urandom, $urandom};
            tick();
            checks++;
            if (o_din_ready !== (m_phase == 1) || o_valid !== (m_phase == 2)) begin
                errors++;
                $display("[TB] FAIL bp_handshake cyc %0d ready/valid got %b%b want %b%b", budget, o_din_ready, o_valid, (m_phase == 1), (m_phase == 2));
            end
            budget++;
        end
        checks++;
        if (m_phase != 2) begin errors++; $display("[TB] FAIL bp_collect_timeout cycles %0d want done", budget); end
        for (int n = 0; n < 10; n++) begin
            i_din_valid = 1'($urandom);
            i_din = {$urandom, $urandom};
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_din_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold valid/ready got %b%b want 10", o_valid, o_din_ready); end
            checks++;
            if (o_ibytes !== m_bus()) begin
                errors++;
                k = bus_diff(o_ibytes, m_bus());
                $display("[TB] FAIL bp_bus_stable byte %0d got %02h want %02h", k, o_ibytes[TOT-1-8*k -: 8], m_bytes[k]);
            end
        end
        checks++;
        if (o_err !== exp_err()) begin errors++; $display("[TB] FAIL bp_err got %b want %b", o_err, exp_err()); end
        i_din_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_accept valid/busy got %b%b want 00", o_valid, o_busy); end
        drive_idle();
    endtask

    task automatic test_abort();
        int k;
        i_start = 1'b1; i_eta = 2'd3;
        tick();
        i_start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            i_din_valid = 1'b1;
            i_din = {$urandom, $urandom};
            tick();
        end
        i_start = 1'b1;
        i_din = {$urandom, $urandom};
        tick();
        i_start = 1'b0;
        checks++;
        if (o_ibytes !== '0) begin errors++; $display("[TB] FAIL abort_clear byte %0d not zero got %02h", bus_diff(o_ibytes, '0), o_ibytes[TOT-1-8*bus_diff(o_ibytes, '0) -: 8]); end
        checks++;
        if (o_din_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_state ready/valid got %b%b want 10", o_din_ready, o_valid); end
        for (int c = 0; c < 24; c++) begin
            i_din = {$urandom, $urandom};
            tick();
            if (c == 22 || c == 23) begin
                checks++;
                if (o_valid !== (c == 23)) begin errors++; $display("[TB] FAIL abort_valid_beat%0d got %b want %b", c, o_valid, (c == 23)); end
            end
        end
        i_din_valid = 1'b0;
        checks++;
        if (o_ibytes !== m_bus()) begin
            errors++;
            k = bus_diff(o_ibytes, m_bus());
            $display("[TB] FAIL abort_bus byte %0d got %02h want %02h", k, o_ibytes[TOT-1-8*k -: 8], m_bytes[k]);
        end
    endtask

    task automatic test_start_on_handshake();
        i_ready = 1'b1;
        i_start = 1'b1;
        i_eta   = 2'd2;
        tick();
        drive_idle();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b1 || o_din_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_handshake valid/busy/ready got %b%b%b want 011", o_valid, o_busy, o_din_ready);
        end
        checks++;
        if (o_ibytes !== '0) begin errors++; $display("[TB] FAIL restart_bus not cleared byte %0d", bus_diff(o_ibytes, '0)); end
    endtask

    task automatic test_reset_midfill();
        for (int c = 0; c < 5; c++) begin
            i_din_valid = 1'b1;
            i_din = {$urandom, $urandom};
            tick();
        end
        #2;
        i_rstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_din_ready !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset valid/ready/busy/err got %b%b%b%b want 0000", o_valid, o_din_ready, o_busy, o_err);
        end
        checks++;
        if (o_ibytes !== '0) begin errors++; $display("[TB] FAIL async_reset_bus byte %0d not zero", bus_diff(o_ibytes, '0)); end
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            i_din_valid = 1'b1;
            i_din = {$urandom, $urandom};
            tick();
            checks++;
            if (o_din_ready !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_ibytes !== '0) begin
                errors++;
                $display("[TB] FAIL post_reset_ignore cyc %0d ready/valid/busy got %b%b%b want 000", c, o_din_ready, o_valid, o_busy);
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_err();
        i_din_valid = 1'b1;
        tick();
        i_din_valid = 1'b0;
        checks++;
        if (o_err !== exp_err()) begin errors++; $display("[TB] FAIL err_idle_valid got %b want %b", o_err, exp_err()); end
        tick();
        tick();
        checks++;
        if (o_err !== exp_err()) begin errors++; $display("[TB] FAIL err_sticky got %b want %b", o_err, exp_err()); end
        i_start = 1'b1; i_eta = 2'd2;
        tick();
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear_on_start got %b want 0", o_err); end
        i_eta = 2'd1;
        tick();
        i_start = 1'b0;
        checks++;
        if (o_err !== exp_err()) begin errors++; $display("[TB] FAIL err_bad_eta got %b want %b", o_err, exp_err()); end
        for (int c = 0; c < 24; c++) begin
            i_din_valid = 1'b1;
            i_din = {$urandom, $urandom};
            tick();
            if (c == 15 || c == 23) begin
                checks++;
                if (o_valid !== (c == 23)) begin errors++; $display("[TB] FAIL eta1_len_beat%0d valid got %b want %b", c, o_valid, (c == 23)); end
            end
        end
        i_din_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        drive_idle();
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 1500; n++) begin
            i_start     = ($urandom_range(0, 39) == 0);
            i_eta       = 2'($urandom_range(0, 3));
            i_din_valid = 1'($urandom);
            i_ready     = ($urandom_range(0, 3) == 0);
            i_din       = {$urandom, $urandom};
            tick();
            checks++;
            if (o_din_ready !== (m_phase == 1) || o_valid !== (m_phase == 2) || o_busy !== (m_phase != 0) || o_err !== exp_err()) begin
                errors++;
                $display("[TB] FAIL rand_ctrl cyc %0d ready/valid/busy/err got %b%b%b%b want %b%b%b%b", n,
                         o_din_ready, o_valid, o_busy, o_err, (m_phase == 1), (m_phase == 2), (m_phase != 0), exp_err());
            end
            checks++;
            if (o_ibytes !== m_bus()) begin
                errors++;
                k = bus_diff(o_ibytes, m_bus());
                $display("[TB] FAIL rand_bus cyc %0d byte %0d got %02h want %02h", n, k, o_ibytes[TOT-1-8*k -: 8], m_bus() >> (TOT - 8 - 8*k) & 8'hff);
            end
        end
        drive_idle();
    endtask

    initial begin
        model_reset();
        drive_idle();
        repeat (2) @(posedge i_clk);
        #1;
        test_reset();
        i_rstn = 1'b1;
        tick();
        test_eta2_sequential();
        test_eta3_backpressure();
        test_abort();
        test_start_on_handshake();
        test_reset_midfill();
        test_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
